// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the NZCV flags, evaluates the condition field
// and gates decoder write/branch controls. Define COND_STATS_EN for exec/skip counters.
module cond_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic       stall,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic [3:0] flags_q,
    output logic       cond_ex,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
`endif
);

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("cond_unit: CNT_W must be at least 1");
    end

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic flag_upd_c;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition decode against the stored (previous-instruction) flags only.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = ~flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = ~flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = ~flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = ~flag_v;
            COND_HI: cond_ex = flag_c & ~flag_z;
            COND_LS: cond_ex = ~flag_c | flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_ex = flag_z | (flag_n != flag_v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign pc_src    = pcs & cond_ex & valid;
    assign reg_write = reg_w & ~no_write & cond_ex & valid;
    assign mem_write = mem_w & cond_ex & valid;

    assign flag_upd_c = valid & ~stall & cond_ex;

    // NZ and CV halves update independently under flag_w.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flags_q <= 4'b0000;
        end else if (flag_upd_c) begin
            if (flag_w[1]) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0]) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating counts of executed and skipped valid instructions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (valid && !stall) begin
            if (cond_ex) begin
                if (exec_cnt != CNT_MAX) begin
                    exec_cnt <= exec_cnt + CNT_W'(1);
                end
            end else begin
                if (skip_cnt != CNT_MAX) begin
                    skip_cnt <= skip_cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: flag model plus per-cycle output compare.
module tb_cond_unit;

    localparam int unsigned TB_CNT_W = 2;
    localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       stall;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic [3:0] flags_q;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
`ifdef COND_STATS_EN
    logic [TB_CNT_W-1:0] exec_cnt;
    logic [TB_CNT_W-1:0] skip_cnt;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    logic check_en = 1'b0;

    logic [3:0] m_flags;
    int         m_exec;
    int         m_skip;

    cond_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .stall     (stall),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .flags_q   (flags_q),
        .cond_ex   (cond_ex),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write)
`ifdef COND_STATS_EN
        ,
        .exec_cnt  (exec_cnt),
        .skip_cnt  (skip_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Condition codes come in predicate/negated-predicate pairs; 1110/1111 is always/never.
    function automatic logic exp_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model of the flag register and statistics.
    always @(posedge clk) begin
        if (!rst) begin
            m_flags <= 4'b0000;
            m_exec  <= 0;
            m_skip  <= 0;
        end else if (!stall && valid) begin
            if (exp_pass(cond, m_flags)) begin
                if (flag_w[1]) m_flags[3:2] <= alu_flags[3:2];
                if (flag_w[0]) m_flags[1:0] <= alu_flags[1:0];
                m_exec <= (m_exec == CNT_MAX) ? m_exec : m_exec + 1;
            end else begin
                m_skip <= (m_skip == CNT_MAX) ? m_skip : m_skip + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic p;
            p = exp_pass(cond, m_flags);
            check("cyc_flags_q", 32'(flags_q), 32'(m_flags));
            check("cyc_cond_ex", 32'(cond_ex), 32'(p));
            check("cyc_pc_src", 32'(pc_src), 32'(pcs && p && valid));
            check("cyc_reg_write", 32'(reg_write), 32'(reg_w && !no_write && p && valid));
            check("cyc_mem_write", 32'(mem_write), 32'(mem_w && p && valid));
`ifdef COND_STATS_EN
            check("cyc_exec_cnt", 32'(exec_cnt), 32'(m_exec));
            check("cyc_skip_cnt", 32'(skip_cnt), 32'(m_skip));
`endif
        end
    end

    task automatic apply(input logic v, input logic s, input logic [3:0] c,
                         input logic [3:0] a, input logic [1:0] fw,
                         input logic p, input logic r, input logic m, input logic nw);
        valid = v; stall = s; cond = c; alu_flags = a; flag_w = fw;
        pcs = p; reg_w = r; mem_w = m; no_write = nw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        apply(1'b1, 1'b0, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        apply(1'b1, 1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        check_en = 1'b1;

        // Reset state and first decode.
        apply(1'b1, 1'b0, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_eq_fail", 32'(cond_ex), 32'h0);
        check("rst_eq_regw", 32'(reg_write), 32'h0);
        tick();
        check("fail_no_write", 32'(flags_q), 32'h0);
        apply(1'b1, 1'b0, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_al_pass", 32'(cond_ex), 32'h1);
        check("rst_al_regw", 32'(reg_write), 32'h1);
        tick();

        // Flag capture.
        check("capture_0110", 32'(flags_q), 32'h6);
        apply(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("capture_eq", 32'(cond_ex), 32'h1);
        tick();
        apply(1'b1, 1'b0, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("capture_ne", 32'(cond_ex), 32'h0);
        tick();

        // Partial writes.
        apply(1'b1, 1'b0, 4'b1110, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("partial_nz", 32'(flags_q), 32'hA);
        apply(1'b1, 1'b0, 4'b1110, 4'b0101, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("partial_cv", 32'(flags_q), 32'h9);

        // Full condition table sweep, checked each cycle by the model compare.
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                apply(1'b0, 1'b0, 4'(c), 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
                tick();
            end
        end

        set_flags(4'b1000);
        apply(1'b0, 1'b0, 4'b1011, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("n1v0_lt", 32'(cond_ex), 32'h1);
        apply(1'b0, 1'b0, 4'b1010, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("n1v0_ge", 32'(cond_ex), 32'h0);
        apply(1'b0, 1'b0, 4'b1101, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("n1v0_le", 32'(cond_ex), 32'h1);
        apply(1'b0, 1'b0, 4'b1100, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("n1v0_gt", 32'(cond_ex), 32'h0);
        tick();
        set_flags(4'b1001);
        apply(1'b0, 1'b0, 4'b1010, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("n1v1_ge", 32'(cond_ex), 32'h1);
        apply(1'b0, 1'b0, 4'b1100, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("n1v1_gt", 32'(cond_ex), 32'h1);
        tick();

        // Gating and suppression.
        set_flags(4'b0000);
        apply(1'b1, 1'b0, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("gate_fail_pc", 32'(pc_src), 32'h0);
        check("gate_fail_reg", 32'(reg_write), 32'h0);
        check("gate_fail_mem", 32'(mem_write), 32'h0);
        tick();
        check("gate_fail_flags", 32'(flags_q), 32'h0);
        apply(1'b0, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("bubble_cond_ex", 32'(cond_ex), 32'h1);
        check("bubble_gated", 32'({pc_src, reg_write, mem_write}), 32'h0);
        tick();
        check("bubble_flags", 32'(flags_q), 32'h0);
        apply(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        check("nowrite_gated", 32'({pc_src, reg_write, mem_write}), 32'h5);
        tick();

        // Stall holds state; outputs still follow inputs.
        apply(1'b1, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("stall_gated", 32'({pc_src, reg_write, mem_write}), 32'h7);
        tick();
        check("stall_flags", 32'(flags_q), 32'h0);

        // Reset during stall clears the flags on the same edge.
        set_flags(4'b1111);
        check("pre_rst_flags", 32'(flags_q), 32'hF);
        rst = 1'b0;
        apply(1'b1, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_stall_flags", 32'(flags_q), 32'h0);
        rst = 1'b1;

        // Statistics saturation.
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        apply(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        check("nv_gated", 32'({cond_ex, pc_src, reg_write, mem_write}), 32'h0);
        tick();
`ifdef COND_STATS_EN
        check("stats_exec_sat", 32'(exec_cnt), 32'h3);
        check("stats_skip", 32'(skip_cnt), 32'h1);
        apply(1'b1, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stats_stall_skip", 32'(skip_cnt), 32'h1);
        check("stats_stall_flags", 32'(flags_q), 32'h0);
`endif
        apply(1'b0, 1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution unit paired with the processor ALU. It consumes the 4-bit ALU flag vector (bit3 N, bit2 Z, bit1 C, bit0 V) and holds it in an architectural NZCV register.
- It evaluates the instruction's 4-bit condition field against the stored flags.
- It gates the decoder's write/branch controls so that failed-condition instructions have no architectural effect.
- It sits between the control decoder, the ALU and the PC/register-file/memory write paths.

Parameters:
CNT_W, 16, width of the optional statistics counters (used only when COND_STATS_EN is defined)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (cleared on the clk edge where rst==0)
valid  in  1  current instruction valid; 0 = bubble
stall  in  1  pipeline hold; freezes all state
cond  in  4  instruction condition field
alu_flags  in  4  flags from ALU for current instruction {N,Z,C,V}
flag_w  in  2  bit1: update N,Z; bit0: update C,V
pcs  in  1  decoder: instruction writes PC
reg_w  in  1  decoder: instruction writes register file
mem_w  in  1  decoder: instruction writes memory
no_write  in  1  decoder: suppress reg write (CMP/CMN/TST)
flags_q  out  4  stored NZCV register
cond_ex  out  1  condition passed for current instruction
pc_src  out  1  pcs & cond_ex & valid
reg_write  out  1  reg_w & ~no_write & cond_ex & valid
mem_write  out  1  mem_w & cond_ex & valid

Behaviour:
- Reset (rst==0 at clk edge): flags_q=4'b0000, optional counters=0. Reset overrides stall and valid.
- Outputs cond_ex, pc_src, reg_write and mem_write are combinational from cond and flags_q. They see flags written by earlier instructions, never the current alu_flags.
- Condition table (N,Z,C,V from flags_q):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
- cond_ex is reported even when valid==0; only the gated outputs depend on valid.
- Flag register update at clk edge when rst==1, stall==0, valid==1 and cond_ex==1:
  - flag_w[1] set: flags_q[3:2] <= alu_flags[3:2].
  - flag_w[0] set: flags_q[1:0] <= alu_flags[1:0].
  - Otherwise the corresponding half holds.
- The update latency is one cycle: the next instruction observes the new flags.
- AND/OR operations deliver alu_flags=0000. If flag_w requests an update, zeros are written; no special-casing.
- Simultaneous events:
  - stall=1: flags and counters hold. Gated outputs still reflect the current inputs; the consumer honours stall.
  - Failed condition: no flag write, even if flag_w != 0.
  - valid=0: no flag write, all gated outputs 0.
- Reset mid-stall: reset wins; the flags clear the same edge.
- No internal X-propagation paths; all outputs are defined from the first cycle after reset.

Optional Feature:
COND_STATS_EN
- Defined:
  - Adds outputs exec_cnt[CNT_W-1:0] and skip_cnt[CNT_W-1:0].
  - On each clk edge with rst==1, stall==0 and valid==1: exec_cnt increments if cond_ex==1, else skip_cnt increments.
  - Both counters saturate at all-ones; no wrap.
  - Reset clears both counters.
- Undefined: ports and counters are absent; remaining behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with stall=1 and valid=1 -> flags_q=0000 and cond=0000 gives cond_ex=0. cond=1110 gives cond_ex=1 and reg_write=reg_w.
- Flag capture: valid=1, cond=1110, flag_w=11, alu_flags=0110 -> next cycle flags_q=0110. cond=0000 gives cond_ex=1; cond=0001 gives cond_ex=0.
- Partial write: flags_q=0110, flag_w=10, alu_flags=1001 -> flags_q=1010. Then flag_w=01, alu_flags=0101 -> flags_q=1001.
- Condition table: for each of 16 flag values × 16 cond codes, compare cond_ex with the table. Specifically, flags_q=1000 gives LT=1, GE=0, LE=1, GT=0; flags_q=1001 gives GE=1, GT=1.
- Gating and suppression:
  - flags_q=0000, cond=0000 (fail), pcs=reg_w=mem_w=1, flag_w=11, alu_flags=1111 -> pc_src=reg_write=mem_write=0 and flags_q stays 0000.
  - valid=0, cond=1110 -> all gated outputs 0.
  - no_write=1 with a passing condition -> reg_write=0.
- Stall and stats (COND_STATS_EN, CNT_W=2): stall=1 with an update requested -> flags_q unchanged and counters unchanged. Then 5 passing valid instructions -> exec_cnt saturates at 3. One NV instruction -> skip_cnt=1.
